// File: rtl/drive_ctrl_nch.sv
// drive_ctrl_nch: N-channel frequency-converter drive controller.
// Each channel synchronises and debounces its panel keys, picks local or
// remote control, and sequences the PWR/STF/STR SSRs with a dead time on
// every rotation change. Channels are fully independent.

module drive_ctrl_ch #(
    parameter int               DEB_TICKS  = 3,
    parameter int               DEAD_TICKS = 50,
    parameter int               LINK_TICKS = 100,
    parameter int               SPD_W      = 10,
    parameter logic [SPD_W-1:0] LOC_SPEED  = SPD_W'(512)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [5:0]       keys,
    input  logic             fault,
    input  logic             rmt_valid,
    input  logic [1:0]       rmt_cmd,
    input  logic [SPD_W-1:0] rmt_speed,
    output logic             pwr,
    output logic             left,
    output logic             right,
    output logic             led_link,
    output logic             led_rmt,
    output logic             led_local,
    output logic             led_on,
    output logic             led_alarm,
    output logic [SPD_W-1:0] speed
);

    // state | meaning
    // OFF   | converter unpowered, all SSRs open
    // IDLE  | powered, no rotation
    // LEFT  | powered, rotating left (STF)
    // RIGHT | powered, rotating right (STR)
    // DEAD  | powered, waiting out the settle time before the target
    // FAULT | converter fault latched, all SSRs open, alarm lit
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LEFT  = 3'd2,
        ST_RIGHT = 3'd3,
        ST_DEAD  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam int K_MD    = 0;
    localparam int K_ON    = 1;
    localparam int K_OFF   = 2;
    localparam int K_LEFT  = 3;
    localparam int K_RIGHT = 4;
    localparam int K_LOCK  = 5;

    localparam logic [3:0] DEB_LAST  = 4'(DEB_TICKS - 1);
    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TICKS);
    localparam logic [9:0] LINK_MAX  = 10'(LINK_TICKS);

    logic [6:0]      sync1;
    logic [6:0]      sync2;
    logic [5:0]      deb;
    logic [5:0][3:0] deb_cnt;
    logic [1:0]      deb_q;
    logic            local_q;
    logic            fault_s;
    logic            local_mode;
    logic            mode_chg;
    logic            on_press;
    logic            off_press;
    logic            off_req;
    logic            up_req;

    state_t           state;
    state_t           state_nxt;
    state_t           tgt;
    state_t           tgt_nxt;
    logic [7:0]       dead_cnt;
    logic [7:0]       dead_nxt;
    logic [9:0]       wd_cnt;
    logic [9:0]       wd_nxt;
    logic             link_lost;
    logic [SPD_W-1:0] spd_lat;
    logic [SPD_W-1:0] spd_nxt;

    logic             pwr_nxt;
    logic             left_nxt;
    logic             right_nxt;
    logic             alarm_nxt;
    logic [SPD_W-1:0] speed_nxt;

    // Two-flop synchroniser for the asynchronous keys and fault level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {fault, keys};
            sync2 <= sync1;
        end
    end

    assign fault_s = sync2[6];

    // Tick-sampled debounce: a key flips only after DEB_TICKS differing samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb     <= '0;
            deb_cnt <= '0;
        end else if (tick) begin
            for (int k = 0; k < 6; k++) begin
                if (sync2[k] != deb[k]) begin
                    if (deb_cnt[k] == DEB_LAST) begin
                        deb[k]     <= sync2[k];
                        deb_cnt[k] <= '0;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + 4'd1;
                    end
                end else begin
                    deb_cnt[k] <= '0;
                end
            end
        end
    end

    // Delayed copies for press edges and mode-change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q   <= '0;
            local_q <= 1'b0;
        end else begin
            deb_q   <= {deb[K_OFF], deb[K_ON]};
            local_q <= local_mode;
        end
    end

    assign local_mode = deb[K_MD] & ~deb[K_LOCK];
    assign mode_chg   = local_mode ^ local_q;
    assign on_press   = deb[K_ON] & ~deb_q[0];
    assign off_press  = deb[K_OFF] & ~deb_q[1];
    assign off_req    = local_mode ? off_press : (rmt_valid && rmt_cmd == 2'b11);
    assign up_req     = local_mode ? on_press  : (rmt_valid && rmt_cmd != 2'b11);
    assign link_lost  = (wd_cnt == LINK_MAX);

    // Watchdog: a remote strobe clears the count even when a tick lands on the same clk.
    always_comb begin
        wd_nxt = wd_cnt;
        if (rmt_valid) begin
            wd_nxt = '0;
        end else if (tick && wd_cnt != LINK_MAX) begin
            wd_nxt = wd_cnt + 10'd1;
        end
    end

    // State register together with target, timers, speed latch and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_OFF;
            tgt       <= ST_IDLE;
            dead_cnt  <= '0;
            wd_cnt    <= LINK_MAX;
            spd_lat   <= '0;
            pwr       <= 1'b0;
            left      <= 1'b0;
            right     <= 1'b0;
            led_on    <= 1'b0;
            led_alarm <= 1'b0;
            led_link  <= 1'b0;
            led_local <= 1'b0;
            led_rmt   <= 1'b1;
            speed     <= '0;
        end else begin
            state     <= state_nxt;
            tgt       <= tgt_nxt;
            dead_cnt  <= dead_nxt;
            wd_cnt    <= wd_nxt;
            spd_lat   <= spd_nxt;
            pwr       <= pwr_nxt;
            left      <= left_nxt;
            right     <= right_nxt;
            led_on    <= left_nxt | right_nxt;
            led_alarm <= alarm_nxt;
            led_link  <= (wd_nxt < LINK_MAX);
            led_local <= local_mode;
            led_rmt   <= ~local_mode;
            speed     <= speed_nxt;
        end
    end

    // Next target, next state and dead-time counter; fault beats off beats direction.
    always_comb begin
        tgt_nxt   = tgt;
        spd_nxt   = spd_lat;
        state_nxt = state;
        dead_nxt  = dead_cnt;

        if (mode_chg) begin
            tgt_nxt = ST_IDLE;
        end else if (local_mode) begin
            case ({deb[K_RIGHT], deb[K_LEFT]})
                2'b01:   tgt_nxt = ST_LEFT;
                2'b10:   tgt_nxt = ST_RIGHT;
                default: tgt_nxt = ST_IDLE;
            endcase
        end else if (rmt_valid) begin
            spd_nxt = rmt_speed;
            case (rmt_cmd)
                2'b01:   tgt_nxt = ST_LEFT;
                2'b10:   tgt_nxt = ST_RIGHT;
                default: tgt_nxt = ST_IDLE;
            endcase
        end else if (link_lost && (state == ST_LEFT || state == ST_RIGHT)) begin
            tgt_nxt = ST_IDLE;
        end

        if (fault_s) begin
            state_nxt = ST_FAULT;
        end else if (state == ST_FAULT) begin
            if (off_req) state_nxt = ST_OFF;
        end else if (off_req) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF:   if (up_req) state_nxt = ST_DEAD;
                ST_IDLE:  if (tgt_nxt != ST_IDLE) state_nxt = tgt_nxt;
                ST_LEFT:  if (tgt_nxt != ST_LEFT) state_nxt = ST_DEAD;
                ST_RIGHT: if (tgt_nxt != ST_RIGHT) state_nxt = ST_DEAD;
                ST_DEAD:  if (dead_cnt == 8'd0) state_nxt = tgt_nxt;
                default:  state_nxt = ST_OFF;
            endcase
        end

        // Counter restarts only on entry; a retarget inside DEAD keeps the running count.
        if (state_nxt == ST_DEAD && state != ST_DEAD) begin
            dead_nxt = DEAD_LOAD;
        end else if (state == ST_DEAD && tick && dead_cnt != 8'd0) begin
            dead_nxt = dead_cnt - 8'd1;
        end
    end

    // Output decode from the next state so outputs register alongside the state.
    always_comb begin
        pwr_nxt   = (state_nxt == ST_IDLE) || (state_nxt == ST_LEFT) ||
                    (state_nxt == ST_RIGHT) || (state_nxt == ST_DEAD);
        left_nxt  = (state_nxt == ST_LEFT);
        right_nxt = (state_nxt == ST_RIGHT);
        alarm_nxt = (state_nxt == ST_FAULT);
        speed_nxt = '0;
        if (left_nxt || right_nxt) begin
            speed_nxt = local_mode ? LOC_SPEED : spd_nxt;
        end
    end

endmodule

module drive_ctrl_nch #(
    parameter int               CH_NUM     = 2,
    parameter int               DEB_TICKS  = 3,
    parameter int               DEAD_TICKS = 50,
    parameter int               LINK_TICKS = 100,
    parameter int               SPD_W      = 10,
    parameter logic [SPD_W-1:0] LOC_SPEED  = SPD_W'(512)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_in,
    input  logic [CH_NUM-1:0]       key_md_in,
    input  logic [CH_NUM-1:0]       key_on_in,
    input  logic [CH_NUM-1:0]       key_off_in,
    input  logic [CH_NUM-1:0]       key_left_in,
    input  logic [CH_NUM-1:0]       key_right_in,
    input  logic [CH_NUM-1:0]       key_lock_in,
    input  logic [CH_NUM-1:0]       fault_in,
    input  logic [CH_NUM-1:0]       rmt_valid_in,
    input  logic [2*CH_NUM-1:0]     rmt_cmd_in,
    input  logic [SPD_W*CH_NUM-1:0] rmt_speed_in,
    output logic [CH_NUM-1:0]       pwr_out,
    output logic [CH_NUM-1:0]       left_out,
    output logic [CH_NUM-1:0]       right_out,
    output logic [CH_NUM-1:0]       led_link_out,
    output logic [CH_NUM-1:0]       led_rmt_out,
    output logic [CH_NUM-1:0]       led_local_out,
    output logic [CH_NUM-1:0]       led_on_out,
    output logic [CH_NUM-1:0]       led_alarm_out,
    output logic [SPD_W*CH_NUM-1:0] speed_out
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        drive_ctrl_ch #(
            .DEB_TICKS (DEB_TICKS),
            .DEAD_TICKS(DEAD_TICKS),
            .LINK_TICKS(LINK_TICKS),
            .SPD_W     (SPD_W),
            .LOC_SPEED (LOC_SPEED)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick_in),
            .keys     ({key_lock_in[i], key_right_in[i], key_left_in[i],
                        key_off_in[i], key_on_in[i], key_md_in[i]}),
            .fault    (fault_in[i]),
            .rmt_valid(rmt_valid_in[i]),
            .rmt_cmd  (rmt_cmd_in[2*i +: 2]),
            .rmt_speed(rmt_speed_in[SPD_W*i +: SPD_W]),
            .pwr      (pwr_out[i]),
            .left     (left_out[i]),
            .right    (right_out[i]),
            .led_link (led_link_out[i]),
            .led_rmt  (led_rmt_out[i]),
            .led_local(led_local_out[i]),
            .led_on   (led_on_out[i]),
            .led_alarm(led_alarm_out[i]),
            .speed    (speed_out[SPD_W*i +: SPD_W])
        );
    end

endmodule

// File: tb/tb_drive_ctrl_nch.sv
// Bench for drive_ctrl_nch: directed scenarios plus a randomized remote
// command run checked against a settled-state model of the drive.

module tb_drive_ctrl_nch;

    localparam int CH = 2;
    localparam int SW = 10;

    logic            clk;
    logic            rst;
    logic            tick_in;
    logic [CH-1:0]   key_md_in, key_on_in, key_off_in, key_left_in, key_right_in, key_lock_in;
    logic [CH-1:0]   fault_in, rmt_valid_in;
    logic [2*CH-1:0] rmt_cmd_in;
    logic [SW*CH-1:0] rmt_speed_in;
    logic [CH-1:0]   pwr_out, left_out, right_out;
    logic [CH-1:0]   led_link_out, led_rmt_out, led_local_out, led_on_out, led_alarm_out;
    logic [SW*CH-1:0] speed_out;

    int checks = 0;
    int failures = 0;
    int overlap_cnt = 0;
    int e;
    logic [1:0] cmd;
    logic [9:0] spd;
    logic [9:0] spd_r;
    bit         m_on;
    int         m_dir;

    drive_ctrl_nch #(
        .CH_NUM(CH), .DEB_TICKS(3), .DEAD_TICKS(4), .LINK_TICKS(8),
        .SPD_W(SW), .LOC_SPEED(10'd512)
    ) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in),
        .key_md_in(key_md_in), .key_on_in(key_on_in), .key_off_in(key_off_in),
        .key_left_in(key_left_in), .key_right_in(key_right_in), .key_lock_in(key_lock_in),
        .fault_in(fault_in), .rmt_valid_in(rmt_valid_in), .rmt_cmd_in(rmt_cmd_in),
        .rmt_speed_in(rmt_speed_in),
        .pwr_out(pwr_out), .left_out(left_out), .right_out(right_out),
        .led_link_out(led_link_out), .led_rmt_out(led_rmt_out), .led_local_out(led_local_out),
        .led_on_out(led_on_out), .led_alarm_out(led_alarm_out), .speed_out(speed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 100 Hz strobe stand-in: one clk high every 10 clks.
    initial begin
        tick_in = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            tick_in = 1'b1;
            @(negedge clk);
            tick_in = 1'b0;
        end
    end

    // Both rotation SSRs on together is never allowed.
    always @(negedge clk) begin
        if (|(left_out & right_out)) overlap_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        wait_clk(10 * n);
    endtask

    task automatic send_rmt(input int ch, input logic [1:0] c, input logic [9:0] s);
        rmt_valid_in[ch]        = 1'b1;
        rmt_cmd_in[2*ch +: 2]   = c;
        rmt_speed_in[SW*ch +: SW] = s;
        @(negedge clk);
        rmt_valid_in[ch] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key_md_in = '0; key_on_in = '0; key_off_in = '0;
        key_left_in = '0; key_right_in = '0; key_lock_in = '0;
        fault_in = '0; rmt_valid_in = '0; rmt_cmd_in = '0; rmt_speed_in = '0;
        wait_clk(5);
        check_val("rst_pwr", pwr_out, 0);
        check_val("rst_led_rmt", led_rmt_out, 3);
        check_val("rst_led_link", led_link_out, 0);
        check_val("rst_speed", speed_out, 0);
        rst = 1'b0;
        wait_clk(1);
        check_val("rst_led_local", led_local_out, 0);
        check_val("rst_alarm", led_alarm_out, 0);

        wait_ticks(20);
        check_val("idle_ssr", {pwr_out, left_out, right_out}, 0);
        check_val("idle_led_rmt", led_rmt_out, 3);
        check_val("idle_led_link", led_link_out, 0);
        check_val("idle_speed", speed_out, 0);

        // ch0 remote left at speed 300
        send_rmt(0, 2'b01, 10'd300);
        check_val("ch0_pwr_next", pwr_out[0], 1);
        check_val("ch0_left_not_yet", left_out[0], 0);
        check_val("ch1_untouched", {pwr_out[1], left_out[1], right_out[1]}, 0);
        e = 0;
        while (!left_out[0] && e < 100) begin @(negedge clk); e++; end
        check_val("ch0_left_arrive", left_out[0], 1);
        check_val("ch0_left_dwell_in_window", (e >= 30 && e <= 42), 1);
        check_val("ch0_speed_300", speed_out[9:0], 300);
        check_val("ch0_led_on", led_on_out[0], 1);

        // reverse to right via dead time
        spd_r = 10'($urandom_range(1, 1023));
        send_rmt(0, 2'b10, spd_r);
        check_val("ch0_rev_left_off", left_out[0], 0);
        check_val("ch0_rev_pwr_kept", pwr_out[0], 1);
        check_val("ch0_rev_speed_zero", speed_out[9:0], 0);
        e = 0;
        while (!right_out[0] && e < 100) begin @(negedge clk); e++; end
        check_val("ch0_right_arrive", right_out[0], 1);
        check_val("ch0_right_dwell_in_window", (e >= 30 && e <= 42), 1);
        check_val("ch0_speed_rand", speed_out[9:0], spd_r);

        // watchdog: link still good at 6 ticks, lost and stopped by 14
        wait_clk(60 - e);
        check_val("ch0_link_6t", led_link_out[0], 1);
        check_val("ch0_right_6t", right_out[0], 1);
        wait_ticks(8);
        check_val("ch0_link_lost", led_link_out[0], 0);
        check_val("ch0_wd_right_off", right_out[0], 0);
        check_val("ch0_wd_pwr_kept", pwr_out[0], 1);
        check_val("ch0_wd_speed", speed_out[9:0], 0);
        send_rmt(0, 2'b00, 10'd0);
        check_val("ch0_link_back", led_link_out[0], 1);

        // randomized remote commands on ch1, compared once settled
        m_on = 0; m_dir = 0;
        for (int i = 0; i < 12; i++) begin
            cmd = 2'($urandom_range(0, 3));
            spd = 10'($urandom_range(0, 1023));
            send_rmt(1, cmd, spd);
            if (cmd == 2'b11) begin
                m_on = 0; m_dir = 0;
            end else begin
                m_on = 1; m_dir = int'(cmd);
            end
            wait_ticks(6);
            check_val("rnd_pwr", pwr_out[1], 32'(m_on));
            check_val("rnd_left", left_out[1], 32'(m_dir == 1));
            check_val("rnd_right", right_out[1], 32'(m_dir == 2));
            check_val("rnd_speed", speed_out[19:10], (m_dir != 0) ? 32'(spd) : 32'd0);
        end
        send_rmt(1, 2'b11, 10'd0);
        wait_clk(2);
        check_val("rnd_final_off", pwr_out[1], 0);
        check_val("ch0_during_rnd", {pwr_out[0], left_out[0], right_out[0]}, 3'b100);

        // ch1 local control
        key_md_in[1] = 1'b1;
        wait_ticks(5);
        check_val("ch1_led_local", led_local_out[1], 1);
        check_val("ch1_led_rmt", led_rmt_out[1], 0);
        check_val("ch1_local_off", pwr_out[1], 0);
        key_on_in[1] = 1'b1;
        wait_ticks(4);
        key_on_in[1] = 1'b0;
        key_right_in[1] = 1'b1;
        wait_ticks(12);
        check_val("ch1_local_right", right_out[1], 1);
        check_val("ch1_local_pwr", pwr_out[1], 1);
        check_val("ch1_local_speed", speed_out[19:10], 512);
        key_off_in[1] = 1'b1;
        wait_clk(20);
        key_off_in[1] = 1'b0;
        wait_ticks(5);
        check_val("ch1_glitch_ignored", {pwr_out[1], right_out[1]}, 2'b11);
        key_off_in[1] = 1'b1;
        e = 0;
        while (pwr_out[1] && e < 100) begin @(negedge clk); e++; end
        check_val("ch1_off_pwr", pwr_out[1], 0);
        check_val("ch1_off_right_same_clk", right_out[1], 0);
        check_val("ch1_off_latency_ok", (e >= 20 && e <= 36), 1);
        key_off_in[1] = 1'b0;
        key_right_in[1] = 1'b0;
        key_md_in[1] = 1'b0;
        wait_ticks(5);
        check_val("ch1_back_remote", led_rmt_out[1], 1);

        // fault on ch0 while LEFT; IDLE goes straight to LEFT
        send_rmt(0, 2'b01, 10'd77);
        check_val("ch0_idle_to_left_direct", left_out[0], 1);
        fault_in[0] = 1'b1;
        wait_clk(2);
        check_val("ch0_fault_not_yet", left_out[0], 1);
        wait_clk(1);
        check_val("ch0_fault_ssr", {pwr_out[0], left_out[0], right_out[0]}, 0);
        check_val("ch0_fault_alarm", led_alarm_out[0], 1);
        check_val("ch0_fault_speed", speed_out[9:0], 0);
        send_rmt(0, 2'b11, 10'd0);
        check_val("ch0_fault_held", led_alarm_out[0], 1);
        fault_in[0] = 1'b0;
        wait_clk(5);
        check_val("ch0_fault_latched", led_alarm_out[0], 1);
        send_rmt(0, 2'b11, 10'd0);
        check_val("ch0_fault_cleared", led_alarm_out[0], 0);
        check_val("ch0_after_fault_pwr", pwr_out[0], 0);

        // reset in the middle of DEAD
        send_rmt(0, 2'b01, 10'd100);
        check_val("ch0_dead_pwr", pwr_out[0], 1);
        wait_ticks(2);
        rst = 1'b1;
        #1;
        check_val("midrst_pwr", pwr_out, 0);
        check_val("midrst_led_rmt", led_rmt_out, 3);
        wait_clk(2);
        rst = 1'b0;
        wait_ticks(8);
        check_val("midrst_no_held", {pwr_out[0], left_out[0]}, 0);

        check_val("never_both_dirs", overlap_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
